bcd_frame_receiver: RTL and testbench
=====================================

# bcd_frame_receiver

Byte-write responder for the BCD display link. It sits at the far end of the 8-bit `we_i`/`reg_sel_i` write interface driven by the BCD formatting FSM. It accepts one command byte followed by `BYTES` data bytes, MSB first, and rebuilds the packed frame. It presents the frame with a valid/ack handshake, echoes the command, and flags protocol errors.

## Interface
- `BYTES`, default 3: data bytes per frame, minimum 2. Frame width is `8*BYTES`.
- `clk_i` in 1: single clock; all logic on the rising edge.
- `rst_i` in 1: reset, synchronous and active-high.
- `we_i` in 1: write strobe. Held-high strobes count as one write.
- `reg_sel_i` in 1: byte type, 1 = command, 0 = data. Sampled with the strobe.
- `data_i` in 8: write byte. Sampled with the strobe.
- `frame_ack_i` in 1: consumer accepts the held frame.
- `err_clr_i` in 1: clears `err_o`.
- `frame_o` out `8*BYTES`: assembled frame. The first data byte is placed in bits [8*BYTES-1 : 8*BYTES-8].
- `frame_valid_o` out 1: level signal, high while a complete frame is held.
- `cmd_o` out 8: last accepted command byte.
- `cmd_valid_o` out 1: one-cycle pulse when a command is accepted.
- `ready_o` out 1: high in IDLE, meaning the block can take a new frame.
- `err_o` out 1: sticky protocol-error flag.

## Operation
- **Write detect:** `wr = we_i & ~we_q`, where `we_q` is `we_i` registered.
  - `we_q` loads `we_i` even while `rst_i` is high, so a strobe held across reset release is not a write.
  - A command write is `wr & reg_sel_i`; a data write is `wr & ~reg_sel_i`.
- **Counter:** byte counter `cnt` has width $clog2(BYTES).
- **Shift rule:** each accepted data byte updates `frame <= {frame[8*BYTES-9:0], data_i}`.
- **IDLE**
  - Command write: load `cmd_o`, pulse `cmd_valid_o`, clear `cnt` and `frame`, go to COLLECT.
  - Data write: drop the byte, set `err_o`.
- **COLLECT**
  - Data write: shift the byte in.
    - If `cnt == BYTES-1`: go to HOLD and set `frame_valid_o`.
    - Otherwise: `cnt++`.
  - Command write: abort the partial frame, set `err_o`, then restart exactly as a command write in IDLE (stay in COLLECT).
- **HOLD**
  - `frame_o` and `frame_valid_o` stay stable until the cycle `frame_ack_i` is high.
  - `frame_ack_i` alone: clear `frame_valid_o`, go to IDLE.
  - `frame_ack_i` plus a command write in the same cycle: the ack completes and the command is accepted, going straight to COLLECT with a `cmd_valid_o` pulse.
  - Any data write (with or without ack): dropped, `err_o` set (overrun).
  - Command write without ack: dropped, `err_o` set.
- **Error flag:** `err_o` clears only on `err_clr_i` or reset. If a set and a clear occur in the same cycle, the set wins.
- **Ack outside HOLD:** ignored.
- **Reset:** all outputs 0, `frame_o` 0, `cmd_o` 0, state IDLE, `cnt` 0. On the cycle after reset deasserts, `ready_o` = 1.
  - Reset during COLLECT or HOLD discards everything; no `frame_valid_o` pulse follows.

## Timing
- Write latency: the effects of a write are visible on outputs one cycle after the edge where `we_i` is first sampled high.
- Frame latency: the command plus `BYTES` data writes, each with at least one `we_i` low cycle between them. `frame_valid_o` rises 1 cycle after the last data strobe is sampled.
- Minimum write spacing: 2 cycles (high, low). Back-to-back high cycles count as a single write.
- `cmd_valid_o` lasts exactly one cycle.
- `ready_o` is high for every cycle in IDLE and low otherwise.
- Ack: `frame_valid_o` falls on the edge that samples `frame_ack_i` = 1, so it is low from the following cycle.

## Structure
- Package `bcd_rx_pkg`:
  - state enum `rx_state_t` {IDLE, COLLECT, HOLD};
  - `localparam BYTE_W = 8`;
  - the command/data encoding of `reg_sel_i` as named constants `RS_CMD = 1'b1` and `RS_DATA = 1'b0`.
- Sub-module `write_strobe_detect`:
  - holds the `we_q` register and produces the one-cycle `wr` pulse;
  - has the reset behaviour described above.
- Main body: one `always_ff` for state, counter, frame, command and error; one `always_comb` for next-state logic.

## Test plan
- Nominal frame with `BYTES` = 3:
  - stimulus: command 0x80, then data 0x12, 0x34, 0x56;
  - required: `cmd_o` = 0x80 with a 1-cycle `cmd_valid_o` pulse; `frame_o` = 0x123456; `frame_valid_o` held until ack, then `ready_o` = 1.
- Held strobe: `we_i` high for 4 cycles with data 0xAA in COLLECT -> exactly one byte shifted in, `cnt` advances by 1.
- Abort:
  - stimulus: command 0x01, data 0x11, then command 0x02, data 0x21, 0x22, 0x23;
  - required: `err_o` = 1; `cmd_o` = 0x02; `frame_o` = 0x212223.
- Overrun and simultaneous ack:
  - stimulus: in HOLD with 0x123456, data write 0x99, then a command write 0x40 together with `frame_ack_i`;
  - required: `frame_o` stays 0x123456 until the ack; `err_o` = 1; `cmd_o` = 0x40 with a pulse; state COLLECT.
- Error flag priority: stray data write in IDLE with `err_clr_i` high in the same cycle -> `err_o` = 1. A later lone `err_clr_i` -> `err_o` = 0.
- Reset mid-frame:
  - stimulus: `rst_i` after 2 data bytes, with `we_i` held high across release;
  - required: all outputs 0; no frame produced; no spurious write counted after release.

Source files
------------

// File: rtl/bcd_rx_pkg.sv
// Shared types and constants for the BCD display link receiver.
package bcd_rx_pkg;

  localparam int BYTE_W = 8;

  localparam logic RS_CMD  = 1'b1;
  localparam logic RS_DATA = 1'b0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } rx_state_t;

endpackage

// File: rtl/write_strobe_detect.sv
// Turns a level write strobe into a one-cycle pulse on its rising edge.
module write_strobe_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic we_i,
  output logic wr_o
);

  logic we_d;
  logic we_q;

  always_comb begin
    we_d = we_i;
  end

  // The strobe is tracked through reset, so a strobe held across release
  // is not seen as a new write.
  always_ff @(posedge clk_i) begin
    we_q <= we_d;
  end

  assign wr_o = we_i & ~we_q & ~rst_i;

endmodule

// File: rtl/bcd_frame_receiver.sv
// Rebuilds a command-prefixed, MSB-first byte frame from the BCD write link.
//   state   | meaning
//   IDLE    | waiting for a command byte, ready_o high
//   COLLECT | command taken, shifting in data bytes
//   HOLD    | full frame presented, waiting for frame_ack_i
module bcd_frame_receiver
  import bcd_rx_pkg::*;
#(
  parameter int BYTES = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    we_i,
  input  logic                    reg_sel_i,
  input  logic [BYTE_W-1:0]       data_i,
  input  logic                    frame_ack_i,
  input  logic                    err_clr_i,
  output logic [BYTE_W*BYTES-1:0] frame_o,
  output logic                    frame_valid_o,
  output logic [BYTE_W-1:0]       cmd_o,
  output logic                    cmd_valid_o,
  output logic                    ready_o,
  output logic                    err_o
);

  localparam int FRAME_W = BYTE_W * BYTES;
  localparam int CNT_W   = $clog2(BYTES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES - 1);

  logic wr;
  logic cmd_wr;
  logic data_wr;

  rx_state_t            state_d, state_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;
  logic [FRAME_W-1:0]   frame_d, frame_q;
  logic [BYTE_W-1:0]    cmd_d, cmd_q;
  logic                 cmd_valid_d, cmd_valid_q;
  logic                 frame_valid_d, frame_valid_q;
  logic                 ready_d, ready_q;
  logic                 err_d, err_q;
  logic                 err_set;

  write_strobe_detect u_wsd (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .we_i  (we_i),
    .wr_o  (wr)
  );

  assign cmd_wr  = wr & (reg_sel_i == RS_CMD);
  assign data_wr = wr & (reg_sel_i == RS_DATA);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_d     = frame_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    err_set     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_wr) begin
          cmd_d       = data_i;
          cmd_valid_d = 1'b1;
          cnt_d       = '0;
          frame_d     = '0;
          state_d     = COLLECT;
        end else if (data_wr) begin
          err_set = 1'b1;
        end
      end
      COLLECT: begin
        if (data_wr) begin
          frame_d = {frame_q[FRAME_W-BYTE_W-1:0], data_i};
          if (cnt_q == CNT_LAST) state_d = HOLD;
          else                   cnt_d   = cnt_q + 1'b1;
        end else if (cmd_wr) begin
          // A new command abandons the partial frame and restarts collection.
          err_set     = 1'b1;
          cmd_d       = data_i;
          cmd_valid_d = 1'b1;
          cnt_d       = '0;
          frame_d     = '0;
        end
      end
      HOLD: begin
        if (data_wr) err_set = 1'b1;
        if (frame_ack_i) begin
          if (cmd_wr) begin
            cmd_d       = data_i;
            cmd_valid_d = 1'b1;
            cnt_d       = '0;
            frame_d     = '0;
            state_d     = COLLECT;
          end else begin
            state_d = IDLE;
          end
        end else if (cmd_wr) begin
          err_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    err_d = err_q;
    if (err_clr_i) err_d = 1'b0;
    if (err_set)   err_d = 1'b1;

    frame_valid_d = (state_d == HOLD);
    ready_d       = (state_d == IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      frame_q       <= '0;
      cmd_q         <= '0;
      cmd_valid_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      ready_q       <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      frame_q       <= frame_d;
      cmd_q         <= cmd_d;
      cmd_valid_q   <= cmd_valid_d;
      frame_valid_q <= frame_valid_d;
      ready_q       <= ready_d;
      err_q         <= err_d;
    end
  end

  assign frame_o       = frame_q;
  assign frame_valid_o = frame_valid_q;
  assign cmd_o         = cmd_q;
  assign cmd_valid_o   = cmd_valid_q;
  assign ready_o       = ready_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_bcd_frame_receiver.sv
// Directed self-checking bench for bcd_frame_receiver with BYTES = 3.
module tb_bcd_frame_receiver;

  localparam int BYTES = 3;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        we_i = 1'b0;
  logic        reg_sel_i = 1'b0;
  logic [7:0]  data_i = 8'h00;
  logic        frame_ack_i = 1'b0;
  logic        err_clr_i = 1'b0;
  logic [23:0] frame_o;
  logic        frame_valid_o;
  logic [7:0]  cmd_o;
  logic        cmd_valid_o;
  logic        ready_o;
  logic        err_o;

  int tests = 0;
  int fails = 0;

  bcd_frame_receiver #(.BYTES(BYTES)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .we_i          (we_i),
    .reg_sel_i     (reg_sel_i),
    .data_i        (data_i),
    .frame_ack_i   (frame_ack_i),
    .err_clr_i     (err_clr_i),
    .frame_o       (frame_o),
    .frame_valid_o (frame_valid_o),
    .cmd_o         (cmd_o),
    .cmd_valid_o   (cmd_valid_o),
    .ready_o       (ready_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe high for one cycle then low for one cycle.
  task automatic wr_byte(input logic sel, input logic [7:0] d);
    we_i = 1'b1; reg_sel_i = sel; data_i = d;
    tick();
    we_i = 1'b0;
    tick();
  endtask

  initial begin
    // Reset
    tick(); tick();
    chk("rst_frame", frame_o, 0);
    chk("rst_valid", frame_valid_o, 0);
    chk("rst_cmd", cmd_o, 0);
    chk("rst_cmd_valid", cmd_valid_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_err", err_o, 0);
    rst_i = 1'b0;
    tick();
    chk("ready_after_rst", ready_o, 1);

    // Nominal frame
    we_i = 1'b1; reg_sel_i = 1'b1; data_i = 8'h80;
    tick();
    chk("nom_cmd", cmd_o, 8'h80);
    chk("nom_cmd_pulse", cmd_valid_o, 1);
    chk("nom_ready_low", ready_o, 0);
    we_i = 1'b0;
    tick();
    chk("nom_cmd_pulse_end", cmd_valid_o, 0);
    wr_byte(1'b0, 8'h12);
    wr_byte(1'b0, 8'h34);
    chk("nom_not_valid_yet", frame_valid_o, 0);
    we_i = 1'b1; reg_sel_i = 1'b0; data_i = 8'h56;
    tick();
    chk("nom_valid_rise", frame_valid_o, 1);
    chk("nom_frame", frame_o, 24'h123456);
    we_i = 1'b0;
    tick(); tick(); tick();
    chk("nom_valid_held", frame_valid_o, 1);
    chk("nom_frame_held", frame_o, 24'h123456);
    frame_ack_i = 1'b1;
    tick();
    frame_ack_i = 1'b0;
    chk("nom_valid_fall", frame_valid_o, 0);
    chk("nom_ready_back", ready_o, 1);
    chk("nom_err", err_o, 0);

    // Held strobe counts once
    wr_byte(1'b1, 8'h05);
    we_i = 1'b1; reg_sel_i = 1'b0; data_i = 8'hAA;
    tick(); tick(); tick(); tick();
    we_i = 1'b0;
    tick();
    chk("held_frame", frame_o, 24'h0000AA);
    chk("held_not_valid", frame_valid_o, 0);
    wr_byte(1'b0, 8'hBB);
    chk("held_second_not_valid", frame_valid_o, 0);
    wr_byte(1'b0, 8'hCC);
    chk("held_valid", frame_valid_o, 1);
    chk("held_final", frame_o, 24'hAABBCC);
    frame_ack_i = 1'b1; tick(); frame_ack_i = 1'b0;

    // Abort by new command
    wr_byte(1'b1, 8'h01);
    wr_byte(1'b0, 8'h11);
    chk("abort_partial", frame_o, 24'h000011);
    we_i = 1'b1; reg_sel_i = 1'b1; data_i = 8'h02;
    tick();
    chk("abort_err", err_o, 1);
    chk("abort_cmd", cmd_o, 8'h02);
    chk("abort_pulse", cmd_valid_o, 1);
    chk("abort_frame_clr", frame_o, 0);
    we_i = 1'b0;
    tick();
    wr_byte(1'b0, 8'h21);
    wr_byte(1'b0, 8'h22);
    wr_byte(1'b0, 8'h23);
    chk("abort_frame", frame_o, 24'h212223);
    chk("abort_valid", frame_valid_o, 1);
    frame_ack_i = 1'b1; tick(); frame_ack_i = 1'b0;
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
    chk("abort_err_cleared", err_o, 0);

    // Overrun, then command together with ack
    wr_byte(1'b1, 8'h80);
    wr_byte(1'b0, 8'h12);
    wr_byte(1'b0, 8'h34);
    wr_byte(1'b0, 8'h56);
    wr_byte(1'b0, 8'h99);
    chk("ovr_err", err_o, 1);
    chk("ovr_frame_kept", frame_o, 24'h123456);
    chk("ovr_valid_kept", frame_valid_o, 1);
    we_i = 1'b1; reg_sel_i = 1'b1; data_i = 8'h40; frame_ack_i = 1'b1;
    tick();
    frame_ack_i = 1'b0;
    chk("ackcmd_cmd", cmd_o, 8'h40);
    chk("ackcmd_pulse", cmd_valid_o, 1);
    chk("ackcmd_valid_low", frame_valid_o, 0);
    chk("ackcmd_ready_low", ready_o, 0);
    chk("ackcmd_err", err_o, 1);
    we_i = 1'b0;
    tick();
    wr_byte(1'b0, 8'h01);
    wr_byte(1'b0, 8'h02);
    wr_byte(1'b0, 8'h03);
    chk("ackcmd_collect_frame", frame_o, 24'h010203);
    chk("ackcmd_collect_valid", frame_valid_o, 1);
    frame_ack_i = 1'b1; tick(); frame_ack_i = 1'b0;
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
    chk("ovr_err_cleared", err_o, 0);

    // Set beats clear in the same cycle
    we_i = 1'b1; reg_sel_i = 1'b0; data_i = 8'h77; err_clr_i = 1'b1;
    tick();
    we_i = 1'b0; err_clr_i = 1'b0;
    chk("prio_set_wins", err_o, 1);
    chk("prio_ready", ready_o, 1);
    tick();
    chk("prio_sticky", err_o, 1);
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
    chk("prio_cleared", err_o, 0);

    // Reset mid-frame with strobe held across release
    wr_byte(1'b1, 8'h33);
    wr_byte(1'b0, 8'h44);
    wr_byte(1'b0, 8'h55);
    we_i = 1'b1; reg_sel_i = 1'b0; data_i = 8'h66; rst_i = 1'b1;
    tick(); tick();
    chk("mrst_frame", frame_o, 0);
    chk("mrst_cmd", cmd_o, 0);
    chk("mrst_ready", ready_o, 0);
    chk("mrst_valid", frame_valid_o, 0);
    rst_i = 1'b0;
    tick();
    chk("mrst_ready_after", ready_o, 1);
    chk("mrst_no_spurious_err", err_o, 0);
    tick(); tick();
    we_i = 1'b0;
    tick();
    chk("mrst_no_frame", frame_valid_o, 0);
    chk("mrst_frame_zero", frame_o, 0);
    chk("mrst_err_still_zero", err_o, 0);
    chk("mrst_cmd_pulse_none", cmd_valid_o, 0);

    // Normal operation resumes
    wr_byte(1'b1, 8'h10);
    wr_byte(1'b0, 8'hA1);
    wr_byte(1'b0, 8'hB2);
    wr_byte(1'b0, 8'hC3);
    chk("resume_frame", frame_o, 24'hA1B2C3);
    chk("resume_cmd", cmd_o, 8'h10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
